// File: rtl/calc_sequencer.sv
// Calculator operation sequencer: latches operands, loads an operand/op program
// into the processor's instruction memory, runs it for a fixed budget, returns the result.
module calc_sequencer #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int RUN_ALU = 11,
  parameter int RUN_DIV = 334
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] dato_a,
  input  logic [DATA_W-1:0] dato_b,
  input  logic [2:0]        operacion,
  output logic              write_ins,
  output logic [ADDR_W-1:0] ins_address,
  output logic [31:0]       ins,
  output logic              proc_run,
  input  logic [31:0]       resultado_in,
  output logic [31:0]       resultado,
  output logic              busy,
  output logic              ready,
  output logic              error,
  output logic [1:0]        error_code
);

  localparam int NB   = DATA_W / 8;
  localparam int IW   = ADDR_W + 1;
  localparam int RMAX = (RUN_ALU > RUN_DIV) ? RUN_ALU : RUN_DIV;
  localparam int CW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_a, r_b;
  logic [2:0]        r_op;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_cnt;
  logic              r_write, r_run, r_busy, r_ready, r_error;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_ins, r_res;
  logic [1:0]        r_ecode;

  logic              w_is_div;
  logic [IW-1:0]     w_nwords;
  logic [CW-1:0]     w_last_cnt;
  logic [1:0]        w_k;
  logic [3:0]        w_r;
  logic [31:0]       w_word;

  // Byte k of an operand sits at bit 8k, so the immediate is rotated right by 2*(16-4k).
  function automatic logic [3:0] f_rot(input logic [1:0] k);
    return 4'd0 - {k, 2'b00};
  endfunction

  // Restoring division: $0 = quotient (shifted in), $2 = remainder, $3 = bit counter.
  function automatic logic [31:0] f_div_word(input logic [3:0] r, input logic is_mod);
    case (r)
      4'd0:    return 32'hF3A02000;
      4'd1:    return 32'hF3A03020;
      4'd2:    return 32'hF1B00080;
      4'd3:    return 32'hF0A22002;
      4'd4:    return 32'hF1520001;
      4'd5:    return 32'h20422001;
      4'd6:    return 32'h23800001;
      4'd7:    return 32'hF2433001;
      4'd8:    return 32'hF3530000;
      4'd9:    return 32'hF3A04000;
      4'd10:   return 32'h03A04001;
      4'd11:   return 32'hF3540000;
      4'd12:   return 32'h0AFFFFF4;
      4'd13:   return 32'hF1A00000;
      4'd14:   return is_mod ? 32'hF282F000 : 32'hF280F000;
      default: return 32'h0;
    endcase
  endfunction

  assign w_is_div   = (r_op == 3'd3) || (r_op == 3'd4);
  assign w_nwords   = IW'(2 * NB) + (w_is_div ? IW'(15) : IW'(1));
  assign w_last_cnt = w_is_div ? CW'(RUN_DIV - 1) : CW'(RUN_ALU - 1);

  always_comb begin
    w_k    = 2'd0;
    w_r    = 4'd0;
    w_word = 32'h0;
    if (r_idx < IW'(NB)) begin
      w_k    = r_idx[1:0];
      w_word = {12'hF38, 4'h0, 4'h0, f_rot(w_k), 8'(r_a >> {w_k, 3'b000})};
    end else if (r_idx < IW'(2 * NB)) begin
      w_k    = 2'(r_idx - IW'(NB));
      w_word = {12'hF38, 4'h1, 4'h1, f_rot(w_k), 8'(r_b >> {w_k, 3'b000})};
    end else begin
      w_r = 4'(r_idx - IW'(2 * NB));
      case (r_op)
        3'd0:    w_word = 32'hF08F0001;
        3'd1:    w_word = 32'hF04F0001;
        3'd2:    w_word = 32'hF000F001;
        default: w_word = f_div_word(w_r, r_op == 3'd4);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_ins   <= '0;
      r_run   <= 1'b0;
      r_res   <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
      r_ecode <= '0;
    end else if (abort && r_state != S_IDLE) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_run   <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
          r_write <= 1'b0;
          r_run   <= 1'b0;
          if (start) begin
            r_a     <= dato_a;
            r_b     <= dato_b;
            r_op    <= operacion;
            r_error <= 1'b0;
            r_ecode <= 2'b00;
            if (operacion > 3'd4) begin
              r_ecode <= 2'b10;
              r_res   <= '0;
              r_state <= S_DONE;
            end else if ((operacion == 3'd3 || operacion == 3'd4) && dato_b == '0) begin
              r_ecode <= 2'b01;
              r_res   <= '0;
              r_state <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_idx   <= '0;
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (r_idx < w_nwords) begin
            r_write <= 1'b1;
            r_addr  <= r_idx[ADDR_W-1:0];
            r_ins   <= w_word;
            r_idx   <= r_idx + 1'b1;
          end else begin
            r_write <= 1'b0;
            r_run   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_cnt == w_last_cnt) begin
            r_res   <= resultado_in;
            r_run   <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_error <= (r_ecode != 2'b00);
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          // Error entries arrive with ready low and pulse it here; normal entries already pulsed.
          if (!r_ready) begin
            r_ready <= 1'b1;
            r_error <= (r_ecode != 2'b00);
          end else begin
            r_ready <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign write_ins   = r_write;
  assign ins_address = r_addr;
  assign ins         = r_ins;
  assign proc_run    = r_run;
  assign resultado   = r_res;
  assign busy        = r_busy;
  assign ready       = r_ready;
  assign error       = r_error;
  assign error_code  = r_ecode;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: 32-bit and 16-bit instances with a simple processor stand-in.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst32, rst16;
  logic        start32, start16, abort32, abort16;
  logic [31:0] tb_a, tb_b;
  logic [2:0]  tb_op;

  logic        wr32, run32, busy32, rdy32, err32;
  logic [4:0]  addr32;
  logic [31:0] ins32, res32, res_in32;
  logic [1:0]  ec32;

  logic        wr16, run16, busy16, rdy16, err16;
  logic [4:0]  addr16;
  logic [31:0] ins16, res16, res_in16;
  logic [1:0]  ec16;

  logic [31:0] exp_res;
  logic [31:0] mem [0:31];
  bit          use16;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat, nwr, nrun;

  always #5 clk = ~clk;

  calc_sequencer #(.DATA_W(32)) u_dut32 (
    .clk(clk), .reset_n(rst32), .start(start32), .abort(abort32),
    .dato_a(tb_a), .dato_b(tb_b), .operacion(tb_op),
    .write_ins(wr32), .ins_address(addr32), .ins(ins32), .proc_run(run32),
    .resultado_in(res_in32), .resultado(res32), .busy(busy32), .ready(rdy32),
    .error(err32), .error_code(ec32)
  );

  calc_sequencer #(.DATA_W(16)) u_dut16 (
    .clk(clk), .reset_n(rst16), .start(start16), .abort(abort16),
    .dato_a(tb_a[15:0]), .dato_b(tb_b[15:0]), .operacion(tb_op),
    .write_ins(wr16), .ins_address(addr16), .ins(ins16), .proc_run(run16),
    .resultado_in(res_in16), .resultado(res16), .busy(busy16), .ready(rdy16),
    .error(err16), .error_code(ec16)
  );

  // Processor stand-in: shows the answer only once it has been allowed to run.
  always @(posedge clk) begin
    res_in32 <= run32 ? exp_res : 32'hBAD0BAD0;
    res_in16 <= run16 ? exp_res : 32'hBAD0BAD0;
  end

  logic        m_wr, m_run, m_rdy;
  logic [4:0]  m_addr;
  logic [31:0] m_ins;
  assign m_wr   = use16 ? wr16   : wr32;
  assign m_run  = use16 ? run16  : run32;
  assign m_rdy  = use16 ? rdy16  : rdy32;
  assign m_addr = use16 ? addr16 : addr32;
  assign m_ins  = use16 ? ins16  : ins32;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one operation and follow it until ready or the cycle budget runs out.
  task automatic do_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input bit with_abort, input int budget);
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    use16 = sel;
    @(negedge clk);
    tb_a = a; tb_b = b; tb_op = op;
    if (sel) begin start16 = 1'b1; abort16 = with_abort; end
    else     begin start32 = 1'b1; abort32 = with_abort; end
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0; start16 = 1'b0; abort32 = 1'b0; abort16 = 1'b0;
    tb_a = ~a; tb_b = ~b; tb_op = 3'd1;
    lat = -1; nwr = 0; nrun = 0;
    for (int c = 0; c < budget; c++) begin
      if (m_wr) begin mem[m_addr] = m_ins; nwr++; end
      if (m_run) nrun++;
      if (m_rdy) begin lat = c; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    int seen, pulses;
    rst32 = 1'b0; rst16 = 1'b0;
    start32 = 1'b0; start16 = 1'b0; abort32 = 1'b0; abort16 = 1'b0;
    tb_a = '0; tb_b = '0; tb_op = '0; exp_res = '0;
    #12;
    chk("rst_ctl", {27'd0, wr32, run32, busy32, rdy32, err32}, 32'h0);
    chk("rst_data", ins32 | res32 | {27'd0, addr32} | {30'd0, ec32}, 32'h0);
    @(negedge clk); rst32 = 1'b1; rst16 = 1'b1;

    exp_res = 32'h1234567D;
    do_op(1'b0, 32'h12345678, 32'h5, 3'd0, 1'b0, 60);
    chk("add_w0", mem[0], 32'hF3800078);
    chk("add_w1", mem[1], 32'hF3800C56);
    chk("add_w2", mem[2], 32'hF3800834);
    chk("add_w3", mem[3], 32'hF3800412);
    chk("add_w4", mem[4], 32'hF3811005);
    chk("add_w5", mem[5], 32'hF3811C00);
    chk("add_w8", mem[8], 32'hF08F0001);
    chk("add_nwr", nwr, 9);
    chk("add_nrun", nrun, 11);
    chk("add_lat", lat, 21);
    chk("add_res", res32, 32'h1234567D);
    chk("add_stat", {29'd0, err32, busy32, rdy32}, 32'h1);

    exp_res = 32'h2;
    do_op(1'b0, 32'h3, 32'h5, 3'd1, 1'b1, 60);
    chk("sub_w8", mem[8], 32'hF04F0001);
    chk("sub_lat", lat, 21);
    chk("sub_res", res32, 32'h2);

    exp_res = 32'h0;
    do_op(1'b0, 32'h10000, 32'h10000, 3'd2, 1'b0, 60);
    chk("mul_w8", mem[8], 32'hF000F001);
    chk("mul_res", res32, 32'h0);

    exp_res = 32'd14;
    do_op(1'b0, 32'd100, 32'd7, 3'd3, 1'b0, 420);
    chk("div_nwr", nwr, 23);
    chk("div_nrun", nrun, 334);
    chk("div_lat", lat, 358);
    chk("div_last", mem[22], 32'hF280F000);
    chk("div_res", res32, 32'd14);

    exp_res = 32'd2;
    do_op(1'b0, 32'd100, 32'd7, 3'd4, 1'b0, 420);
    chk("mod_last", mem[22], 32'hF282F000);
    chk("mod_res", res32, 32'd2);
    chk("mod_err", {30'd0, err32, ec32 != 2'b00}, 32'h0);

    // Abort five cycles into RUN; a start pulse during LOAD must be ignored.
    exp_res = 32'h33;
    use16 = 1'b0;
    @(negedge clk);
    tb_a = 32'h11; tb_b = 32'h22; tb_op = 3'd0; start32 = 1'b1;
    @(posedge clk);
    @(negedge clk); start32 = 1'b0;
    @(negedge clk); @(negedge clk);
    start32 = 1'b1; tb_op = 3'd6;
    @(negedge clk); start32 = 1'b0;
    seen = 0; nwr = 2;
    for (int c = 0; c < 40; c++) begin
      if (run32) begin seen = 1; break; end
      if (wr32) nwr++;
      @(negedge clk);
    end
    chk("abt_run_seen", seen, 1);
    chk("abt_nwr", nwr, 9);
    repeat (4) @(negedge clk);
    abort32 = 1'b1;
    @(negedge clk); abort32 = 1'b0;
    chk("abt_ctl", {29'd0, run32, busy32, wr32}, 32'h0);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (rdy32) pulses++;
      @(negedge clk);
    end
    chk("abt_noready", pulses, 0);
    chk("abt_res", res32, 32'd2);
    chk("abt_ec", {30'd0, ec32}, 32'h0);

    do_op(1'b0, 32'd9, 32'd0, 3'd3, 1'b0, 10);
    chk("dz_nwr", nwr, 0);
    chk("dz_lat", lat, 1);
    chk("dz_err", {29'd0, err32, ec32}, 32'h5);
    chk("dz_res", res32, 32'h0);
    chk("dz_busy", {31'd0, busy32}, 32'h0);

    do_op(1'b0, 32'd9, 32'd3, 3'd6, 1'b0, 10);
    chk("ill_nwr", nwr, 0);
    chk("ill_lat", lat, 1);
    chk("ill_err", {29'd0, err32, ec32}, 32'h6);

    // Held start re-accepts on the first IDLE cycle after each ready.
    @(negedge clk);
    tb_op = 3'd6; start32 = 1'b1;
    @(posedge clk);
    pulses = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (rdy32) pulses++;
    end
    start32 = 1'b0;
    chk("hold_pulses", pulses, 3);
    repeat (4) @(negedge clk);

    exp_res = 32'h0200;
    do_op(1'b1, 32'h00FF, 32'h0101, 3'd0, 1'b0, 60);
    chk("d16_w0", mem[0], 32'hF38000FF);
    chk("d16_w1", mem[1], 32'hF3800C00);
    chk("d16_w2", mem[2], 32'hF3811001);
    chk("d16_w3", mem[3], 32'hF3811C01);
    chk("d16_w4", mem[4], 32'hF08F0001);
    chk("d16_nwr", nwr, 5);
    chk("d16_lat", lat, 17);
    chk("d16_res", res16, 32'h0200);

    // Asynchronous reset in the middle of LOAD.
    @(negedge clk);
    tb_a = 32'h1; tb_b = 32'h2; tb_op = 3'd0; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk); start16 = 1'b0;
    @(negedge clk);
    chk("rst16_pre_wr", {31'd0, wr16}, 32'h1);
    #2 rst16 = 1'b0;
    #1;
    chk("rst16_ctl", {27'd0, wr16, run16, busy16, rdy16, err16}, 32'h0);
    chk("rst16_data", ins16 | res16 | {27'd0, addr16} | {30'd0, ec16}, 32'h0);
    @(negedge clk); rst16 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst16_idle", {29'd0, wr16, busy16, run16}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
